// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared encodings for the multi-cycle MIPS control path.
// Holds the controller state enum, instruction-class enum, opcode/funct
// constants and the datapath select/op encodings driven by mips_mc_ctrl.
package mips_mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPE_EX = 4'd6,
      S_RTYPE_WB = 4'd7,
      S_IMM_EX   = 4'd8,
      S_IMM_WB   = 4'd9,
      S_BEQ_EX   = 4'd10,
      S_JAL      = 4'd11,
      S_JR       = 4'd12
   } state_t;

   typedef enum logic [2:0] {
      CL_NOP, CL_LS, CL_RTYPE, CL_IMM, CL_BEQ, CL_JAL, CL_JR
   } instr_class_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   typedef enum logic [2:0] {ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_PASSB = 3'd3} alu_op_t;
   typedef enum logic [1:0] {EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2} ext_op_t;
   typedef enum logic [1:0] {PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3} pc_src_t;
   typedef enum logic [1:0] {RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2} reg_dst_t;
   typedef enum logic [1:0] {WD_ALUOUT = 2'd0, WD_MDR = 2'd1, WD_PC = 2'd2} wd_sel_t;
   typedef enum logic [1:0] {SRCB_B = 2'd0, SRCB_FOUR = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM4 = 2'd3} alu_src_b_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// mips_mc_ctrl_if: controller <-> datapath bundle.
//   master (controller): reads opcode/funct/zero, drives all control lines
//   slave  (datapath)  : drives opcode/funct/zero, reads control lines
interface mips_mc_ctrl_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       pc_we;
   logic [1:0] pc_src;
   logic       ir_we;
   logic       iord;
   logic       mem_we;
   logic       reg_we;
   logic [1:0] reg_dst;
   logic [1:0] wd_sel;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic [1:0] ext_op;
   logic       instr_done;
   logic [3:0] state;

   modport master (
      input  opcode, funct, zero,
      output pc_we, pc_src, ir_we, iord, mem_we, reg_we, reg_dst, wd_sel,
             alu_src_a, alu_src_b, alu_op, ext_op, instr_done, state
   );

   modport slave (
      output opcode, funct, zero,
      input  pc_we, pc_src, ir_we, iord, mem_we, reg_we, reg_dst, wd_sel,
             alu_src_a, alu_src_b, alu_op, ext_op, instr_done, state
   );
endinterface

// File: rtl/mips_mc_decode.sv
// mips_mc_decode: combinational opcode/funct -> instruction class map.
//   opcode, funct : latched IR fields
//   cls           : class used to pick the DECODE successor state
module mips_mc_decode
   import mips_mc_pkg::*;
(
   input  logic [5:0]   opcode,
   input  logic [5:0]   funct,
   output instr_class_t cls
);
   always_comb begin
      cls = CL_NOP;
      unique case (opcode)
         OP_RTYPE: begin
            if (funct == FN_ADDU || funct == FN_SUBU) cls = CL_RTYPE;
            else if (funct == FN_JR)                  cls = CL_JR;
            else                                      cls = CL_NOP;
         end
         OP_LW, OP_SW:   cls = CL_LS;
         OP_ORI, OP_LUI: cls = CL_IMM;
         OP_BEQ:         cls = CL_BEQ;
         OP_JAL:         cls = CL_JAL;
         default:        cls = CL_NOP;
      endcase
   end
endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: main control FSM of the multi-cycle MIPS core.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; forces FETCH
//   bus   : master side of mips_mc_ctrl_if (IR fields + zero in,
//           datapath control lines and debug state out)
module mips_mc_ctrl
   import mips_mc_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   mips_mc_ctrl_if.master bus
);
   state_t       cur, nxt;
   instr_class_t cls;

   mips_mc_decode u_decode (
      .opcode (bus.opcode),
      .funct  (bus.funct),
      .cls    (cls)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur <= S_FETCH;
      else       cur <= nxt;
   end

   assign bus.state = cur;

   always_comb begin
      nxt            = cur;
      bus.pc_we      = 1'b0;
      bus.pc_src     = PC_ALU;
      bus.ir_we      = 1'b0;
      bus.iord       = 1'b0;
      bus.mem_we     = 1'b0;
      bus.reg_we     = 1'b0;
      bus.reg_dst    = RD_RT;
      bus.wd_sel     = WD_ALUOUT;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = SRCB_B;
      bus.alu_op     = ALU_ADD;
      bus.ext_op     = EXT_ZERO;
      bus.instr_done = 1'b0;

      unique case (cur)
         S_FETCH: begin
            bus.ir_we     = 1'b1;
            bus.pc_we     = 1'b1;
            bus.alu_src_b = SRCB_FOUR;
            nxt           = S_DECODE;
         end
         S_DECODE: begin
            bus.alu_src_b = SRCB_IMM4;
            bus.ext_op    = EXT_SIGN;
            unique case (cls)
               CL_LS:    nxt = S_MEMADR;
               CL_RTYPE: nxt = S_RTYPE_EX;
               CL_IMM:   nxt = S_IMM_EX;
               CL_BEQ:   nxt = S_BEQ_EX;
               CL_JAL:   nxt = S_JAL;
               CL_JR:    nxt = S_JR;
               default: begin
                  bus.instr_done = 1'b1;
                  nxt            = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = SRCB_IMM;
            bus.ext_op    = EXT_SIGN;
            nxt           = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            bus.iord = 1'b1;
            nxt      = S_MEMWB;
         end
         S_MEMWB: begin
            bus.reg_we     = 1'b1;
            bus.wd_sel     = WD_MDR;
            bus.instr_done = 1'b1;
            nxt            = S_FETCH;
         end
         S_MEMWR: begin
            bus.iord       = 1'b1;
            bus.mem_we     = 1'b1;
            bus.instr_done = 1'b1;
            nxt            = S_FETCH;
         end
         S_RTYPE_EX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = (bus.funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
            nxt           = S_RTYPE_WB;
         end
         S_RTYPE_WB: begin
            bus.reg_we     = 1'b1;
            bus.reg_dst    = RD_RD;
            bus.instr_done = 1'b1;
            nxt            = S_FETCH;
         end
         S_IMM_EX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = SRCB_IMM;
            if (bus.opcode == OP_ORI) begin
               bus.ext_op = EXT_ZERO;
               bus.alu_op = ALU_OR;
            end else begin
               bus.ext_op = EXT_LUI;
               bus.alu_op = ALU_PASSB;
            end
            nxt = S_IMM_WB;
         end
         S_IMM_WB: begin
            bus.reg_we     = 1'b1;
            bus.instr_done = 1'b1;
            nxt            = S_FETCH;
         end
         S_BEQ_EX: begin
            bus.alu_src_a  = 1'b1;
            bus.alu_op     = ALU_SUB;
            bus.pc_we      = bus.zero;
            bus.pc_src     = PC_ALUOUT;
            bus.instr_done = 1'b1;
            nxt            = S_FETCH;
         end
         S_JAL: begin
            bus.pc_we      = 1'b1;
            bus.pc_src     = PC_JUMP;
            bus.reg_we     = 1'b1;
            bus.reg_dst    = RD_RA;
            bus.wd_sel     = WD_PC;
            bus.instr_done = 1'b1;
            nxt            = S_FETCH;
         end
         S_JR: begin
            bus.pc_we      = 1'b1;
            bus.pc_src     = PC_RS;
            bus.instr_done = 1'b1;
            nxt            = S_FETCH;
         end
         default: nxt = S_FETCH;
      endcase

      // Reset is asynchronous, so the enables are masked combinationally:
      // state already reads FETCH, but FETCH would otherwise raise pc_we/ir_we.
      if (reset) begin
         bus.pc_we      = 1'b0;
         bus.ir_we      = 1'b0;
         bus.mem_we     = 1'b0;
         bus.reg_we     = 1'b0;
         bus.instr_done = 1'b0;
      end
   end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
module tb_mips_mc_ctrl;
   import mips_mc_pkg::*;

   typedef enum int {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_NOP} kind_t;

   typedef struct packed {
      logic [3:0] st;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       ir_we;
      logic       iord;
      logic       mem_we;
      logic       reg_we;
      logic [1:0] reg_dst;
      logic [1:0] wd_sel;
      logic       asa;
      logic [1:0] asb;
      logic [2:0] aop;
      logic [1:0] ext;
      logic       done;
   } ctrl_t;

   logic  clk = 1'b0;
   logic  reset;
   int    tests = 0;
   int    fails = 0;
   ctrl_t exp_w;
   logic  exp_valid = 1'b0;
   logic  exp_rst = 1'b0;
   string tag = "reset";
   int    step_no = 0;
   ctrl_t log_q [8];
   ctrl_t act_w, msk_w;

   mips_mc_ctrl_if bus ();

   mips_mc_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic kind_t classify(input logic [31:0] w);
      case (w[31:26])
         6'h00: begin
            if (w[5:0] == 6'h21)      return K_ADDU;
            else if (w[5:0] == 6'h23) return K_SUBU;
            else if (w[5:0] == 6'h08) return K_JR;
            else                      return K_NOP;
         end
         6'h0D:   return K_ORI;
         6'h0F:   return K_LUI;
         6'h23:   return K_LW;
         6'h2B:   return K_SW;
         6'h04:   return K_BEQ;
         6'h03:   return K_JAL;
         default: return K_NOP;
      endcase
   endfunction

   // cycles per instruction, FETCH included
   function automatic int ncycles(input kind_t k);
      case (k)
         K_LW:                          return 5;
         K_ADDU, K_SUBU, K_ORI, K_LUI, K_SW: return 4;
         K_BEQ, K_JAL, K_JR:            return 3;
         default:                       return 2;
      endcase
   endfunction

   function automatic ctrl_t model(input kind_t k, input int s, input logic z);
      ctrl_t c = '0;
      if (s == 0) begin
         c.st = S_FETCH; c.ir_we = 1; c.pc_we = 1; c.asb = 2'd1;
      end else if (s == 1) begin
         c.st = S_DECODE; c.asb = 2'd3; c.ext = 2'd1;
      end else begin
         case (k)
            K_LW, K_SW: begin
               if (s == 2) begin
                  c.st = S_MEMADR; c.asa = 1; c.asb = 2'd2; c.ext = 2'd1;
               end else if (k == K_SW) begin
                  c.st = S_MEMWR; c.iord = 1; c.mem_we = 1;
               end else if (s == 3) begin
                  c.st = S_MEMRD; c.iord = 1;
               end else begin
                  c.st = S_MEMWB; c.reg_we = 1; c.wd_sel = 2'd1;
               end
            end
            K_ADDU, K_SUBU: begin
               if (s == 2) begin
                  c.st = S_RTYPE_EX; c.asa = 1; c.aop = (k == K_SUBU) ? 3'd1 : 3'd0;
               end else begin
                  c.st = S_RTYPE_WB; c.reg_we = 1; c.reg_dst = 2'd1;
               end
            end
            K_ORI, K_LUI: begin
               if (s == 2) begin
                  c.st = S_IMM_EX; c.asa = 1; c.asb = 2'd2;
                  c.ext = (k == K_ORI) ? 2'd0 : 2'd2;
                  c.aop = (k == K_ORI) ? 3'd2 : 3'd3;
               end else begin
                  c.st = S_IMM_WB; c.reg_we = 1;
               end
            end
            K_BEQ: begin
               c.st = S_BEQ_EX; c.asa = 1; c.aop = 3'd1; c.pc_we = z; c.pc_src = 2'd1;
            end
            K_JAL: begin
               c.st = S_JAL; c.pc_we = 1; c.pc_src = 2'd2; c.reg_we = 1;
               c.reg_dst = 2'd2; c.wd_sel = 2'd2;
            end
            K_JR: begin
               c.st = S_JR; c.pc_we = 1; c.pc_src = 2'd3;
            end
            default: c = '0;
         endcase
      end
      c.done = (s > 0 && s == ncycles(k) - 1);
      return c;
   endfunction

   function automatic ctrl_t rst_exp();
      ctrl_t c = '0;
      c.st = S_FETCH;
      return c;
   endfunction

   function automatic ctrl_t rst_mask();
      ctrl_t m = '0;
      m.st = '1; m.pc_we = 1; m.ir_we = 1; m.mem_we = 1; m.reg_we = 1; m.done = 1;
      return m;
   endfunction

   function automatic ctrl_t sample();
      ctrl_t c;
      c.st = bus.state;      c.pc_we = bus.pc_we;   c.pc_src = bus.pc_src;
      c.ir_we = bus.ir_we;   c.iord = bus.iord;     c.mem_we = bus.mem_we;
      c.reg_we = bus.reg_we; c.reg_dst = bus.reg_dst; c.wd_sel = bus.wd_sel;
      c.asa = bus.alu_src_a; c.asb = bus.alu_src_b; c.aop = bus.alu_op;
      c.ext = bus.ext_op;    c.done = bus.instr_done;
      return c;
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (exp_valid) begin
         act_w = sample();
         msk_w = exp_rst ? rst_mask() : '1;
         tests++;
         if ((act_w & msk_w) !== (exp_w & msk_w)) begin
            fails++;
            $display("FAIL %s step%0d: got %h (state %0d) want %h (state %0d)",
                     tag, step_no, act_w, act_w.st, exp_w, exp_w.st);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d want %0d", nm, act, expv);
      end
   endtask

   // Runs one instruction starting in FETCH (called at posedge+1).
   // The IR fields change on the edge leaving FETCH, as the real IR does.
   task automatic run(input string nm, input logic [31:0] w, input logic z, input int abort_at);
      kind_t k = classify(w);
      int    n = ncycles(k);
      bit    stop = 0;
      for (int s = 0; s < n && !stop; s++) begin
         tag = nm; step_no = s;
         exp_w = model(k, s, z); exp_rst = 0;
         bus.zero = z;
         #1 log_q[s] = sample();
         if (s == abort_at) begin
            @(negedge clk); #1;
            reset = 1; exp_rst = 1; exp_w = rst_exp();
            #1;
            chk({nm, " mem_we at reset"}, int'(bus.mem_we), 0);
            chk({nm, " state at reset"}, int'(bus.state), 0);
            @(posedge clk); #1;
            @(posedge clk); #1;
            reset = 0; exp_rst = 0;
            stop = 1;
         end else begin
            @(posedge clk); #1;
            if (s == 0) begin
               bus.opcode = w[31:26];
               bus.funct  = w[5:0];
            end
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] w0;
      w0 = 32'h00221821;
      reset = 1'b1;
      bus.zero = 1'b0;
      bus.opcode = w0[31:26];
      bus.funct  = w0[5:0];
      exp_w = rst_exp(); exp_rst = 1'b1; exp_valid = 1'b1;
      #1;
      chk("reset state", int'(bus.state), 0);
      chk("reset ir_we", int'(bus.ir_we), 0);
      chk("reset pc_we", int'(bus.pc_we), 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0; exp_rst = 1'b0;

      // model pins: hand-computed expectations of the bench model itself
      chk("model lw cycles", ncycles(classify(32'h8C220004)), 5);
      chk("model jal step2 pc_src", int'(model(K_JAL, 2, 1'b0).pc_src), 2);

      run("addu", 32'h00221821, 1'b0, -1);
      chk("addu c3 reg_we", int'(log_q[2].reg_we), 0);
      chk("addu c4 reg_we", int'(log_q[3].reg_we), 1);
      chk("addu c4 reg_dst", int'(log_q[3].reg_dst), 1);
      chk("addu c4 done", int'(log_q[3].done), 1);
      run("subu", 32'h00612023, 1'b1, -1);
      chk("subu c3 alu_op", int'(log_q[2].aop), 1);
      run("lw", 32'h8C220004, 1'b0, -1);
      chk("lw memrd iord", int'(log_q[3].iord), 1);
      chk("lw memwb wd_sel", int'(log_q[4].wd_sel), 1);
      chk("lw memwb reg_dst", int'(log_q[4].reg_dst), 0);
      run("sw", 32'hAC220008, 1'b0, -1);
      run("ori", 32'h34210005, 1'b1, -1);
      run("lui", 32'h3C011234, 1'b0, -1);
      chk("lui c3 ext_op", int'(log_q[2].ext), 2);
      run("beq z1", 32'h10220003, 1'b1, -1);
      chk("beq z1 pc_we", int'(log_q[2].pc_we), 1);
      chk("beq z1 pc_src", int'(log_q[2].pc_src), 1);
      run("beq z0", 32'h10220003, 1'b0, -1);
      chk("beq z0 pc_we", int'(log_q[2].pc_we), 0);
      chk("after beq state", int'(bus.state), 0);
      run("jal", 32'h0C000C00, 1'b0, -1);
      chk("jal pc_src", int'(log_q[2].pc_src), 2);
      chk("jal reg_dst", int'(log_q[2].reg_dst), 2);
      chk("jal wd_sel", int'(log_q[2].wd_sel), 2);
      chk("jal reg_we", int'(log_q[2].reg_we), 1);
      run("jr", 32'h03E00008, 1'b1, -1);
      chk("jr pc_src", int'(log_q[2].pc_src), 3);
      run("sll nop", 32'h00000000, 1'b0, -1);
      run("op3f", 32'hFC000000, 1'b1, -1);
      chk("op3f decode done", int'(log_q[1].done), 1);
      run("add unsupported", 32'h00221820, 1'b0, -1);
      run("sw reset", 32'hAC220008, 1'b0, 3);
      chk("sw reset memwr seen", int'(log_q[3].mem_we), 1);
      run("addu after reset", 32'h00221821, 1'b0, -1);

      exp_valid = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Main control FSM for the multi-cycle MIPS core. Each instruction is split into fetch, decode, execute, memory and write-back steps. In each step the block drives the shared datapath resources: the PC, IR, unified memory, register file, ALU and extender. It replaces the single-cycle combinational decoder and sits beside the datapath under `mips`. It observes only the latched instruction fields and the ALU zero flag.

## Interface
Parameters:
- none; all encodings come from `mips_mc_pkg`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high
- `opcode`  in  6  IR[31:26], already registered in the IR
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU result == 0, combinational from the datapath
- `pc_we`  out  1  PC write enable
- `pc_src`  out  2  PC input select: 0 ALU result, 1 ALUOut register, 2 jump target {PC[31:28], imm26, 00}, 3 rs value
- `ir_we`  out  1  IR write enable
- `iord`  out  1  memory address select: 0 PC, 1 ALUOut
- `mem_we`  out  1  memory write enable
- `reg_we`  out  1  register file write enable
- `reg_dst`  out  2  write register select: 0 rt, 1 rd, 2 $31
- `wd_sel`  out  2  write data select: 0 ALUOut, 1 MDR, 2 PC
- `alu_src_a`  out  1  ALU A input: 0 PC, 1 A register
- `alu_src_b`  out  2  ALU B input: 0 B register, 1 constant 4, 2 ext imm, 3 ext imm<<2
- `alu_op`  out  3  ADD=0, SUB=1, OR=2, PASSB=3
- `ext_op`  out  2  extender mode: ZERO=0, SIGN=1, LUI=2
- `instr_done`  out  1  one-cycle pulse in the final state of each instruction
- `state`  out  4  current state, for debug and the bench

## Operation
- Supported instructions:
  - R-type with funct `addu` 100001, `subu` 100011, `jr` 001000
  - `ori` 001101, `lui` 001111, `lw` 100011, `sw` 101011, `beq` 000100, `jal` 000011
- States:
  - FETCH: mem read at PC, `ir_we`=1, ALU computes PC+4, `pc_we`=1, `pc_src`=0
  - DECODE: ALU computes PC + (sext imm<<2) into ALUOut; A and B registers load
- Transitions out of DECODE:
  - lw/sw → MEMADR
  - addu/subu → RTYPE_EX
  - ori/lui → IMM_EX
  - beq → BEQ_EX
  - jal → JAL
  - jr → JR
  - any other opcode/funct, including `sll $0` nop → FETCH, treated as nop with `instr_done`=1 in DECODE
- MEMADR: A + sext imm (ADD, `alu_src_b`=2, `ext_op`=SIGN); then → MEMRD (lw) or MEMWR (sw).
- MEMRD: `iord`=1 read, MDR loads → MEMWB.
- MEMWB: `reg_we`, `reg_dst`=rt, `wd_sel`=MDR, done.
- MEMWR: `iord`=1, `mem_we`=1, done.
- RTYPE_EX: A op B (ADD/SUB) → RTYPE_WB.
- RTYPE_WB: `reg_we`, `reg_dst`=rd, `wd_sel`=ALUOut, done.
- IMM_EX: `alu_src_b`=2. ori: `ext_op`=ZERO, OR. lui: `ext_op`=LUI, PASSB. → IMM_WB.
- IMM_WB: `reg_we`, `reg_dst`=rt, done.
- BEQ_EX: SUB, `pc_we`=`zero`, `pc_src`=1, done.
- JAL: `pc_we`, `pc_src`=2, `reg_we`, `reg_dst`=$31, `wd_sel`=PC (PC already +4), done.
- JR: `pc_we`, `pc_src`=3, done.
- Every done state returns to FETCH.
- Outputs are Moore: a function of the state and the latched opcode/funct. Only BEQ_EX `pc_we` also depends on `zero`.
- Unlisted outputs in any state are 0.

## Timing
- Cycles per instruction, counting FETCH: beq/jal/jr = 3; R-type, ori, lui, sw = 4; lw = 5; nop/unknown = 2.
- Reset behaviour:
  - Asserting `reset` forces `state`=FETCH immediately.
  - While `reset` is high, all write enables and `instr_done` are 0.
  - The first FETCH executes on the first rising edge after release.
- Reset mid-instruction abandons the instruction; no partial write occurs after assertion.
- `instr_done` is high for exactly one cycle per instruction, never in FETCH.
- `opcode`/`funct` may change only on an `ir_we` edge. The block relies on IR stability from DECODE onward.

## Structure
- `mips_mc_pkg` holds:
  - the state enum (4-bit)
  - opcode and funct constants
  - the `alu_op`, `ext_op`, `pc_src`, `reg_dst`, `wd_sel` and `alu_src_b` encodings
- One sub-module, `mips_mc_decode`, is combinational. It maps opcode/funct to an instruction class (LS, RTYPE, IMM, BEQ, JAL, JR, NOP) and is used by the DECODE transition.
- The state register and output logic live in `mips_mc_ctrl`.

## Test plan
- Reset held 3 cycles, then released with IR=`addu $3,$1,$2` → sequence FETCH, DECODE, RTYPE_EX, RTYPE_WB; `reg_we`=1 with `reg_dst`=1 only in cycle 4; `instr_done` in cycle 4.
- `lw` 0x8C220004 → 5 states; `iord`=1 in MEMRD; `wd_sel`=1, `reg_dst`=0 in MEMWB.
- `beq` with `zero`=1 → `pc_we`=1, `pc_src`=1 in cycle 3; with `zero`=0 → `pc_we`=0; both cases back in FETCH in cycle 4.
- `jal` 0x0C000C00 → cycle 3 has `pc_src`=2, `reg_dst`=2, `wd_sel`=2, `reg_we`=1. Follow with `jr $31` → `pc_src`=3 in its cycle 3.
- Reset asserted during MEMWR (before the edge) → `mem_we` drops to 0 combinationally, `state`=FETCH, no write. Also: unknown opcode 0x3F → 2-cycle NOP with `instr_done` in DECODE.
